// File: rtl/alu_if.sv
// alu_if: request/result bundle between the register-file side and alu_sequencer
interface alu_if #(parameter int DATA_WIDTH = 16);
  logic start;
  logic [3:0] opcode;
  logic [DATA_WIDTH-1:0] operand_a, operand_b, data_in_acc_alu;
  logic busy, done, signal_save_after_alu;
  logic flag_z, flag_n, flag_c, flag_v;
  modport master (
    output start, opcode, operand_a, operand_b,
    input busy, done, data_in_acc_alu, signal_save_after_alu, flag_z, flag_n, flag_c, flag_v
  );
  modport slave (
    input start, opcode, operand_a, operand_b,
    output busy, done, data_in_acc_alu, signal_save_after_alu, flag_z, flag_n, flag_c, flag_v
  );
endinterface

// File: rtl/alu_sequencer.sv
// alu_sequencer: multi-cycle ALU feeding the accumulator write port
module alu_sequencer #(parameter int DATA_WIDTH = 16) (
  input logic clk,
  input logic rst,
  alu_if.slave bus
);
  localparam int M = DATA_WIDTH - 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam int SW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH);
  localparam logic [DATA_WIDTH:0] ONE = 1;
  typedef enum logic [1:0] {IDLE, EXEC, ITER, DONE} state_t;
  state_t state, state_n;
  logic [3:0] op;
  logic [M:0] a, b, r, q, res, div_d;
  logic [CW-1:0] cnt;
  logic c, v, ge;
  logic [DATA_WIDTH:0] mul_s, div_t;
  logic [SW-1:0] sh;
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE && bus.start)
      state_n = (bus.opcode inside {4'd11, 4'd12, 4'd13} && bus.operand_b != '0) ? ITER : EXEC;
    else if (state == EXEC || (state == ITER && cnt == LAST)) state_n = DONE;
    else if (state == DONE) state_n = IDLE;
  end
  // res/c/v read only latched registers, so they stay valid through DONE and feed the output load
  always_comb begin
    res = '0;
    c = 1'b0;
    v = 1'b0;
    sh = b[SW-1:0];
    mul_s = {1'b0, r} + {1'b0, q[0] ? a : '0};
    div_t = {r, q[M]};
    ge = div_t >= {1'b0, b};
    div_d = div_t[M:0] - b;
    case (op)
      4'd0: begin
        {c, res} = {1'b0, a} + {1'b0, b};
        v = a[M] == b[M] && res[M] != a[M];
      end
      4'd1, 4'd14: begin
        {c, res} = {1'b0, a} - {1'b0, b};
        v = a[M] != b[M] && res[M] != a[M];
      end
      4'd2: res = a & b;
      4'd3: res = a | b;
      4'd4: res = a ^ b;
      4'd5: res = ~a;
      4'd6: {c, res} = {1'b0, a} << sh;
      4'd7: {res, c} = {a, 1'b0} >> sh;
      4'd8: {res, c} = $signed({a, 1'b0}) >>> sh;
      4'd9: begin
        {c, res} = {1'b0, a} + ONE;
        v = ~a[M] & res[M];
      end
      4'd10: begin
        {c, res} = {1'b0, a} - ONE;
        v = a[M] & ~res[M];
      end
      4'd11: begin
        res = q;
        c = |r;
      end
      4'd12: begin
        res = b == '0 ? '1 : q;
        v = b == '0;
      end
      4'd13: begin
        res = b == '0 ? a : r;
        v = b == '0;
      end
      default: ;
    endcase
  end
  assign bus.busy = state != IDLE;
  // MUL keeps {r,q} as a right-shifting product; DIV shifts the dividend out of q into remainder r
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      op <= '0;
      a <= '0;
      b <= '0;
      r <= '0;
      q <= '0;
      cnt <= '0;
      bus.done <= 1'b0;
      bus.signal_save_after_alu <= 1'b0;
      bus.data_in_acc_alu <= '0;
      {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} <= '0;
    end else begin
      bus.done <= state == DONE;
      bus.signal_save_after_alu <= state == DONE && op < 4'd14;
      if (state == IDLE && bus.start) begin
        op <= bus.opcode;
        a <= bus.operand_a;
        b <= bus.operand_b;
        r <= '0;
        q <= bus.opcode == 4'd11 ? bus.operand_b : bus.operand_a;
        cnt <= '0;
      end
      if (state == ITER && cnt != LAST) begin
        cnt <= cnt + 1'b1;
        r <= op == 4'd11 ? mul_s[DATA_WIDTH:1] : ge ? div_d : div_t[M:0];
        q <= op == 4'd11 ? {mul_s[0], q[M:1]} : {q[M-1:0], ge};
      end
      if (state == DONE && op != 4'd15) begin
        {bus.flag_z, bus.flag_n, bus.flag_c, bus.flag_v} <= {res == '0, res[M], c, v};
        if (op != 4'd14) bus.data_in_acc_alu <= res;
      end
    end
endmodule

// File: doc/alu_sequencer.md
# alu_sequencer

Multi-cycle arithmetic/logic unit sitting between the general-purpose register file and its accumulator write port. It takes the accumulator as operand A and the selected X/Y read data as operand B. It executes single-cycle logic and add/shift operations, and iterative 16-step multiply, divide and modulo. Each completed operation is returned as `data_in_acc_alu` with a one-cycle `signal_save_after_alu` pulse, which commits it to the accumulator.

## Interface
- `DATA_WIDTH`, 16, operand/result width; iteration count for MUL/DIV/MOD equals `DATA_WIDTH`
- `clk`  in  1  rising-edge clock
- `rst`  in  1  asynchronous, active-high reset
- `start`  in  1  request; sampled only in IDLE
- `opcode`  in  4  operation select, sampled with `start`
- `operand_a`  in  DATA_WIDTH  accumulator value, sampled with `start`
- `operand_b`  in  DATA_WIDTH  X/Y read data, sampled with `start`
- `busy`  out  1  high from the edge after accepting `start` until `done`
- `done`  out  1  one-cycle completion pulse
- `data_in_acc_alu`  out  DATA_WIDTH  registered result
- `signal_save_after_alu`  out  1  one-cycle accumulator write strobe
- `flag_z`, `flag_n`, `flag_c`, `flag_v`  out  1 each  registered status flags

## Operation
- States:
  - IDLE: `start`=1 latches opcode/operands. Goes to ITER for opcodes 11–13 with B≠0; otherwise goes to EXEC.
  - EXEC: computes, loads result/flags, goes to DONE.
  - ITER: shift-add multiply or restoring divide, one step per cycle. After step `DATA_WIDTH` it goes to DONE.
  - DONE: pulses `done`, returns to IDLE.
- Opcodes:
  - 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 NOT A
  - 6 SHL A by B[3:0], 7 SHR logical, 8 ASR
  - 9 INC A, 10 DEC A
  - 11 MUL (low half of product), 12 DIV (unsigned quotient), 13 MOD (unsigned remainder)
  - 14 CMP (flags from A−B, no save), 15 reserved (no save, flags unchanged)
- Divide by zero (12/13 with B=0): takes the EXEC path. DIV gives all-ones, MOD gives A; `flag_v`=1.
- Flags (all but opcode 15):
  - Z = result==0; N = result MSB.
  - C: ADD/INC carry-out; SUB/CMP/DEC borrow (unsigned A<B); shifts = last bit shifted out (0 when shift amount is 0); MUL = upper product half nonzero; otherwise 0.
  - V: signed overflow for ADD/SUB/CMP/INC/DEC; divide by zero; otherwise 0.
- `signal_save_after_alu` = `done` AND opcode not in {14, 15}.
- `start` while busy or in DONE is ignored. Latched operands are unaffected by input changes during execution.

## Timing
- Reset: state IDLE; `busy`, `done`, `signal_save_after_alu` = 0; `data_in_acc_alu` = 0; all flags 0. An in-flight operation is abandoned with no save pulse.
- Accepting edge E. Single-cycle ops: result/flags valid and `done`/save high in the cycle after edge E+2. `busy` is high for cycles E+1..E+2.
- MUL/DIV/MOD (B≠0): `done` follows edge E+`DATA_WIDTH`+2 (18 cycles at 16 bits).
- Back-to-back: the earliest next accepted `start` is the edge at which `done` deasserts (DONE→IDLE edge+1). No overlap.
- `data_in_acc_alu` and flags hold their values until the next completion.
- No combinational path from inputs to outputs.

## Test plan
- After reset release, `start`, op 0, A=0x7FFF, B=0x0001 → result 0x8000, N=1, V=1, C=0, Z=0; save pulse 1 cycle at E+2.
- Op 1, A=0x0003, B=0x0005 → 0xFFFE, C=1, N=1; then op 14 with the same operands → flags identical, no save pulse, result holds 0xFFFE.
- Op 11, A=0x0100, B=0x0100 → 0x0000, Z=1, C=1, done at E+18. Then A=0x00FF, B=0x0003 → 0x02FD, C=0.
- Op 12, A=100, B=7 → 0x000E; op 13 → 0x0002. Op 12 with B=0 → 0xFFFF, V=1, done at E+2.
- Mid-DIV: toggle `start`/operands → ignored, result unchanged. Assert `rst` at iteration 8 → all outputs 0 immediately, no save pulse. Next op 6, A=0x8001, B=1 → 0x0002, C=1.
